// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Serial receive front end for the terminal command handler. Recovers 8N1
// bytes from an asynchronous RX line, reports framing and overrun errors as
// single-cycle pulses, and buffers completed bytes in a small circular FIFO
// read through a valid/ready interface.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per serial bit (>= 4)
//   FIFO_ADDR_W   log2 of FIFO depth
//
// Ports:
//   clk            in   system clock
//   clr            in   synchronous active-high reset
//   rx             in   asynchronous serial line, idles high
//   data     [7:0] out  byte at FIFO head (combinational read of head entry)
//   valid          out  FIFO non-empty
//   ready          in   consumer accepts head byte
//   framing_error  out  one-cycle pulse: stop bit sampled low
//   overrun        out  one-cycle pulse: completed byte dropped, FIFO full
//   dbg_state[2:0] out  receive FSM state (0 IDLE, 1 START, 2 DATA,
//                       3 STOP, 4 BREAK)
//
// Handshake: a byte is transferred on every clock edge where valid && ready
// are both high. While valid is high and ready is low, data and valid hold
// their values; the consumer may drop ready at any time without loss.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 208,
    parameter int FIFO_ADDR_W  = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun,
    output logic [2:0] dbg_state
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_ADDR_W;

    // Counter terminal values: a full bit period and the half period used to
    // land the first sample in the middle of the start bit.
    localparam logic [CW-1:0] LAST_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CYC_ONE   = CW'(1);

    localparam logic [FIFO_ADDR_W:0]   DEPTH_C = (FIFO_ADDR_W + 1)'(DEPTH);
    localparam logic [FIFO_ADDR_W:0]   CNT_ONE = (FIFO_ADDR_W + 1)'(1);
    localparam logic [FIFO_ADDR_W-1:0] PTR_ONE = FIFO_ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // ---------------- synchroniser ----------------
    logic r_rx_meta;
    logic r_rx_s;

    // ---------------- receive FSM ----------------
    state_t        r_state;
    logic [CW-1:0] r_cyc;
    logic [2:0]    r_bit;
    logic [7:0]    r_shreg;
    logic          r_ferr;

    state_t        w_state_nx;
    logic [CW-1:0] w_cyc_nx;
    logic [2:0]    w_bit_nx;
    logic [7:0]    w_shreg_nx;
    logic          w_push;
    logic          w_stop_bad;

    // ---------------- FIFO ----------------
    logic [7:0]             r_mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] r_wr_ptr;
    logic [FIFO_ADDR_W-1:0] r_rd_ptr;
    logic [FIFO_ADDR_W:0]   r_count;
    logic                   r_ovr;

    logic w_pop;
    logic w_full;
    logic w_push_ok;

    // Two-flop synchroniser; reset to the idle (high) line level so a reset
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // FSM state register and datapath registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cyc   <= w_cyc_nx;
            r_bit   <= w_bit_nx;
            r_shreg <= w_shreg_nx;
            r_ferr  <= w_stop_bad;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        w_cyc_nx   = r_cyc;
        w_bit_nx   = r_bit;
        w_shreg_nx = r_shreg;
        w_push     = 1'b0;
        w_stop_bad = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nx = S_START;
                    w_cyc_nx   = '0;
                end
            end

            S_START: begin
                if (r_cyc == LAST_HALF) begin
                    w_cyc_nx = '0;
                    if (!r_rx_s) begin
                        w_state_nx = S_DATA;
                        w_bit_nx   = '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_cyc_nx = r_cyc + CYC_ONE;
                end
            end

            S_DATA: begin
                if (r_cyc == LAST_FULL) begin
                    w_cyc_nx   = '0;
                    w_shreg_nx = {r_rx_s, r_shreg[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end else begin
                    w_cyc_nx = r_cyc + CYC_ONE;
                end
            end

            S_STOP: begin
                if (r_cyc == LAST_FULL) begin
                    w_cyc_nx = '0;
                    if (r_rx_s) begin
                        w_push     = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_stop_bad = 1'b1;
                        w_state_nx = S_BREAK;
                    end
                end else begin
                    w_cyc_nx = r_cyc + CYC_ONE;
                end
            end

            S_BREAK: begin
                // Hold here for as long as the line stays low so a break
                // condition produces only the one framing error.
                if (r_rx_s) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_cyc_nx   = '0;
            end
        endcase
    end

    // A push into a full FIFO still succeeds when the head leaves in the
    // same cycle, since the slot being written is freed at that edge.
    assign w_pop     = valid && ready;
    assign w_full    = (r_count == DEPTH_C);
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= r_shreg;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_ovr <= w_push && w_full && !w_pop;
        end
    end

    assign data          = r_mem[r_rd_ptr];
    assign valid         = (r_count != '0);
    assign framing_error = r_ferr;
    assign overrun       = r_ovr;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo at CLKS_PER_BIT=16, depth 4.
// Inputs are driven 1 time unit after the rising edge; the monitor samples
// outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int C  = 16;
    localparam int AW = 2;

    logic       clk = 1'b0;
    logic       clr;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       overrun;
    logic [2:0] dbg_state;

    uart_rx_fifo #(
        .CLKS_PER_BIT (C),
        .FIFO_ADDR_W  (AW)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .rx            (rx),
        .data          (data),
        .valid         (valid),
        .ready         (ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- ready driver ----------------
    // 0: held low, 1: held high, 2: toggles every clock, 3: random
    int rmode = 0;
    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       ready = 1'b0;
                1:       ready = 1'b1;
                2:       ready = ~ready;
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard capture ----------------
    logic [7:0] got_q[$];
    int         pop_cyc[$];
    int         ferr_cnt;
    int         ovr_cnt;
    int         valid_cnt;
    int         first_valid;
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       p_clr   = 1'b1;
    logic [7:0] p_data  = 8'h00;

    always @(negedge clk) begin
        if (p_valid && !p_ready && !p_clr && !clr) begin
            check("hold_valid", valid, 1);
            check("hold_data", data, p_data);
        end
        if (valid && ready) begin
            got_q.push_back(data);
            pop_cyc.push_back(cyc);
        end
        if (valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (framing_error) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (framing_error || overrun) check("err_coincide", framing_error & overrun, 0);
        p_valid = valid;
        p_ready = ready;
        p_clr   = clr;
        p_data  = data;
    end

    task automatic clr_mon();
        got_q.delete();
        pop_cyc.delete();
        ferr_cnt    = 0;
        ovr_cnt     = 0;
        valid_cnt   = 0;
        first_valid = -1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; the line is left
    // at the stop-bit level so back-to-back frames can follow directly.
    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        hold(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(C);
        end
        rx = stop_v;
        hold(C);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        hold(n);
    endtask

    task automatic check_bytes(input string name, input logic [7:0] exp[$]);
        int n;
        check({name, "_count"}, got_q.size(), exp.size());
        n = (got_q.size() < exp.size()) ? got_q.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", name, i), got_q[i], exp[i]);
        end
    endtask

    // ---------------- table of single-frame vectors ----------------
    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         exp_n;
        logic [7:0] exp_b;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    logic [7:0] exp_q[$];
    logic [7:0] e[$];
    int         t0;
    int         exp_ferr;
    logic [7:0] rb;
    logic       rs;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[2] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 8'h00, 1};
        vecs[4] = '{8'h80, 1'b1, 1, 8'h80, 0};
        vecs[5] = '{8'h01, 1'b1, 1, 8'h01, 0};

        // ---- reset state ----
        clr = 1'b1;
        rx  = 1'b1;
        clr_mon();
        hold(3);
        check("rst_valid", valid, 0);
        check("rst_data", data, 8'h00);
        check("rst_ferr", framing_error, 0);
        check("rst_ovr", overrun, 0);
        check("rst_state", dbg_state, 0);
        clr = 1'b0;
        hold(4);

        // ---- single byte 0x41, latency and one-cycle valid ----
        rmode = 1;
        hold(2);
        clr_mon();
        t0 = cyc;
        send_frame(8'h41, 1'b1);
        idle(2 * C);
        // 2 sync + 1 idle detect + half bit + 8 data bits + stop bit
        check("lat_0x41", first_valid - t0, 3 + C / 2 + 9 * C);
        check("valid_len", valid_cnt, 1);
        e = '{8'h41};
        check_bytes("single", e);
        check("single_ferr", ferr_cnt, 0);

        // ---- fill FIFO with ready low, then overrun ----
        rmode = 0;
        hold(2);
        clr_mon();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        send_frame(8'h04, 1'b1);
        idle(C);
        check("full_valid", valid, 1);
        check("full_head", data, 8'h01);
        check("full_no_ovr", ovr_cnt, 0);
        send_frame(8'h55, 1'b1);
        idle(2 * C);
        check("ovr_pulses", ovr_cnt, 1);
        check("ovr_head", data, 8'h01);
        rmode = 1;
        hold(10);
        e = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_bytes("drain", e);
        if (pop_cyc.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("drain_gap%0d", i), pop_cyc[i + 1] - pop_cyc[i], 1);
            end
        end
        check("drain_empty", valid, 0);
        check("drain_ferr", ferr_cnt, 0);

        // ---- bad stop bit, break, then good frame ----
        clr_mon();
        send_frame(8'h7E, 1'b0);
        hold(3 * C);
        idle(2 * C);
        send_frame(8'h33, 1'b1);
        idle(2 * C);
        check("break_ferr", ferr_cnt, 1);
        check("break_ovr", ovr_cnt, 0);
        e = '{8'h33};
        check_bytes("break", e);

        // ---- short low glitch ----
        clr_mon();
        rx = 1'b0;
        hold(C / 4);
        check("glitch_start", dbg_state, 1);
        rx = 1'b1;
        hold(3 * C);
        check("glitch_valid", valid_cnt, 0);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_ovr", ovr_cnt, 0);
        check("glitch_idle", dbg_state, 0);

        // ---- table-driven single frames ----
        rmode = 1;
        for (int v = 0; v < 6; v++) begin
            clr_mon();
            send_frame(vecs[v].b, vecs[v].stop);
            idle(2 * C);
            check($sformatf("vec%0d_n", v), got_q.size(), vecs[v].exp_n);
            if (got_q.size() > 0 && vecs[v].exp_n > 0) begin
                check($sformatf("vec%0d_b", v), got_q[0], vecs[v].exp_b);
            end
            check($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
        end

        // ---- toggling ready, clr mid-frame ----
        rmode = 2;
        clr_mon();
        send_frame(8'hA1, 1'b1);
        send_frame(8'hB2, 1'b1);
        send_frame(8'hC3, 1'b1);
        rx = 1'b0;
        hold(C);
        rx = 1'b1;
        hold(C);
        rx = 1'b0;
        hold(C / 2);
        clr = 1'b1;
        rx  = 1'b1;
        hold(1);
        clr = 1'b0;
        check("clr_valid", valid, 0);
        check("clr_data", data, 8'h00);
        check("clr_state", dbg_state, 0);
        e = '{8'hA1, 8'hB2, 8'hC3};
        check_bytes("toggle", e);
        clr_mon();
        idle(2 * C);
        send_frame(8'h5A, 1'b1);
        idle(2 * C);
        e = '{8'h5A};
        check_bytes("after_clr", e);
        check("after_clr_ferr", ferr_cnt, 0);

        // ---- randomized frames vs reference list ----
        rmode = 3;
        clr_mon();
        exp_q.delete();
        exp_ferr = 0;
        for (int k = 0; k < 24; k++) begin
            rb = 8'($urandom());
            rs = ($urandom_range(0, 5) != 0);
            if (rs) exp_q.push_back(rb);
            else exp_ferr++;
            send_frame(rb, rs);
            idle($urandom_range(1, 3) * C);
        end
        rmode = 1;
        idle(2 * C);
        check_bytes("rand", exp_q);
        check("rand_ferr", ferr_cnt, exp_ferr);
        check("rand_ovr", ovr_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
